// File: rtl/pe_ctrl_seq_if.sv
// rtl/pe_ctrl_seq_if.sv - instruction handshake bundle for the PE sequencer
interface pe_ctrl_seq_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 inst_v;
    logic                 inst_rdy;
    logic [2:0]           opcode;
    logic [CNT_WIDTH-1:0] rep_cnt;

    modport master (output inst_v, output opcode, output rep_cnt, input inst_rdy);
    modport slave  (input inst_v, input opcode, input rep_cnt, output inst_rdy);
endinterface

// File: rtl/pe_ctrl_seq.sv
// rtl/pe_ctrl_seq.sv - PE instruction sequencer, DSP48 lane decoder and data-output mux
module pe_ctrl_seq #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_DSP       = 4,
    parameter int LAT           = 7,
    parameter int CNT_WIDTH     = 8,
    parameter int ALUMODE_WIDTH = 4,
    parameter int INMODE_WIDTH  = 5,
    parameter int OPMODE_WIDTH  = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    pe_ctrl_seq_if.slave                      inst_if,
    input  logic                              din_pe_v,
    input  logic [2*DATA_WIDTH-1:0]           din_pe,
    input  logic                              din_shift_v,
    input  logic [2*DATA_WIDTH-1:0]           din_shift,
    input  logic                              din_tx_v,
    input  logic [2*DATA_WIDTH-1:0]           din_tx,
    output logic [2*DATA_WIDTH-1:0]           dout,
    output logic                              dout_v,
    output logic                              busy,
    output logic                              illegal_op,
    output logic [ALUMODE_WIDTH*NUM_DSP-1:0]  alumode,
    output logic [INMODE_WIDTH*NUM_DSP-1:0]   inmode,
    output logic [OPMODE_WIDTH*NUM_DSP-1:0]   opmode,
    output logic [NUM_DSP-1:0]                cea2,
    output logic [NUM_DSP-1:0]                ceb2,
    output logic [NUM_DSP-1:0]                usemult
);
    localparam int AW = ALUMODE_WIDTH;
    localparam int IW = INMODE_WIDTH;
    localparam int OW = OPMODE_WIDTH;

    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_RSVD   = 3'b011;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_MULADD = 3'b101;
    localparam logic [2:0] OP_MULSUB = 3'b110;
    localparam logic [2:0] OP_MAX    = 3'b111;

    localparam logic [AW-1:0] ALU_ADD = '0;
    localparam logic [AW-1:0] ALU_SUB = AW'(3);
    localparam logic [IW-1:0] INM_MUL = IW'(17);
    localparam logic [OW-1:0] OPM_ADD = OW'(51);
    localparam logic [OW-1:0] OPM_MUL = OW'(5);
    localparam logic [OW-1:0] OPM_MAC = OW'(53);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [2:0]              op_q, op_d;
    logic                    ill_q, ill_d;
    logic [LAT-1:0]          dl_q, dl_d;
    logic [2*DATA_WIDTH-1:0] dout_q, dout_d;
    logic [AW*NUM_DSP-1:0]   alumode_q, alumode_d;
    logic [IW*NUM_DSP-1:0]   inmode_q, inmode_d;
    logic [OW*NUM_DSP-1:0]   opmode_q, opmode_d;
    logic [NUM_DSP-1:0]      cea2_q, cea2_d, ceb2_q, ceb2_d, usemult_q, usemult_d;

    logic issue, rdy, accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ill_d   = 1'b0;
        issue   = (state_q == ISSUE);
        rdy     = (state_q == IDLE) || (issue && cnt_q == '0);
        accept  = inst_if.inst_v && rdy;
        if (issue && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (accept) begin
            // Reserved opcode only flags; it never occupies an issue slot.
            if (inst_if.opcode == OP_RSVD) begin
                ill_d   = 1'b1;
                state_d = IDLE;
            end else begin
                op_d    = inst_if.opcode;
                cnt_d   = inst_if.rep_cnt;
                state_d = ISSUE;
            end
        end else if (issue && cnt_q == '0) begin
            state_d = IDLE;
        end
    end

    // Decode from next-state so the registered fields line up with the issue cycle.
    always_comb begin
        alumode_d = '0;
        inmode_d  = '0;
        opmode_d  = '0;
        cea2_d    = '0;
        ceb2_d    = '0;
        usemult_d = '0;
        if (state_d == ISSUE) begin
            for (int i = 0; i < NUM_DSP; i++) begin
                case (op_d)
                    OP_ADD, OP_SUB: begin
                        alumode_d[i*AW +: AW] = (op_d == OP_SUB) ? ALU_SUB : ALU_ADD;
                        opmode_d[i*OW +: OW]  = OPM_ADD;
                        cea2_d[i]             = 1'b1;
                        ceb2_d[i]             = 1'b1;
                    end
                    OP_MUL, OP_MULADD, OP_MULSUB, OP_MAX: begin
                        inmode_d[i*IW +: IW]  = INM_MUL;
                        usemult_d[i]          = 1'b1;
                        opmode_d[i*OW +: OW]  = ((i % 2 == 1) && (op_d == OP_MULADD || op_d == OP_MULSUB))
                                                ? OPM_MAC : OPM_MUL;
                        alumode_d[i*AW +: AW] = ((i % 2 == 1) && op_d == OP_MULSUB) ? ALU_SUB : ALU_ADD;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        dl_d   = {dl_q[LAT-2:0], issue};
        dout_d = dout_q;
        if (din_pe_v) begin
            dout_d = din_pe;
        end else if (din_shift_v) begin
            dout_d = din_shift;
        end else if (din_tx_v) begin
            dout_d = din_tx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            ill_q     <= 1'b0;
            dl_q      <= '0;
            dout_q    <= '0;
            alumode_q <= '0;
            inmode_q  <= '0;
            opmode_q  <= '0;
            cea2_q    <= '0;
            ceb2_q    <= '0;
            usemult_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            ill_q     <= ill_d;
            dl_q      <= dl_d;
            dout_q    <= dout_d;
            alumode_q <= alumode_d;
            inmode_q  <= inmode_d;
            opmode_q  <= opmode_d;
            cea2_q    <= cea2_d;
            ceb2_q    <= ceb2_d;
            usemult_q <= usemult_d;
        end
    end

    assign inst_if.inst_rdy = rdy;
    assign dout             = dout_q;
    assign dout_v           = dl_q[LAT-1];
    assign busy             = issue || (|dl_q);
    assign illegal_op       = ill_q;
    assign alumode          = alumode_q;
    assign inmode           = inmode_q;
    assign opmode           = opmode_q;
    assign cea2             = cea2_q;
    assign ceb2             = ceb2_q;
    assign usemult          = usemult_q;
endmodule

// File: tb/tb_pe_ctrl_seq.sv
// tb/tb_pe_ctrl_seq.sv - directed bench for pe_ctrl_seq at three parameter points
module tb_pe_ctrl_seq;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          inst_v = 1'b0;
    logic [2:0]    opcode = '0;
    logic [CW-1:0] rep_cnt = '0;
    logic          din_pe_v = 1'b0, din_shift_v = 1'b0, din_tx_v = 1'b0;
    logic [31:0]   din_pe = '0, din_shift = '0, din_tx = '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pe_ctrl_seq_if #(.CNT_WIDTH(CW)) if4 ();
    pe_ctrl_seq_if #(.CNT_WIDTH(CW)) if2 ();
    pe_ctrl_seq_if #(.CNT_WIDTH(CW)) if8 ();
    assign if4.inst_v = inst_v;  assign if4.opcode = opcode;  assign if4.rep_cnt = rep_cnt;
    assign if2.inst_v = inst_v;  assign if2.opcode = opcode;  assign if2.rep_cnt = rep_cnt;
    assign if8.inst_v = inst_v;  assign if8.opcode = opcode;  assign if8.rep_cnt = rep_cnt;

    logic [31:0] d4_dout, d2_dout, d8_dout;
    logic        d4_dv, d2_dv, d8_dv, d4_busy, d2_busy, d8_busy, d4_ill, d2_ill, d8_ill;
    logic [15:0] d4_alu;  logic [19:0] d4_inm;  logic [27:0] d4_opm;  logic [3:0] d4_cea, d4_ceb, d4_um;
    logic [7:0]  d2_alu;  logic [9:0]  d2_inm;  logic [13:0] d2_opm;  logic [1:0] d2_cea, d2_ceb, d2_um;
    logic [31:0] d8_alu;  logic [39:0] d8_inm;  logic [55:0] d8_opm;  logic [7:0] d8_cea, d8_ceb, d8_um;

    pe_ctrl_seq #(.NUM_DSP(4), .LAT(7)) dut4 (
        .clk(clk), .rst(rst), .inst_if(if4),
        .din_pe_v(din_pe_v), .din_pe(din_pe), .din_shift_v(din_shift_v), .din_shift(din_shift),
        .din_tx_v(din_tx_v), .din_tx(din_tx), .dout(d4_dout), .dout_v(d4_dv), .busy(d4_busy),
        .illegal_op(d4_ill), .alumode(d4_alu), .inmode(d4_inm), .opmode(d4_opm),
        .cea2(d4_cea), .ceb2(d4_ceb), .usemult(d4_um));
    pe_ctrl_seq #(.NUM_DSP(2), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .inst_if(if2),
        .din_pe_v(din_pe_v), .din_pe(din_pe), .din_shift_v(din_shift_v), .din_shift(din_shift),
        .din_tx_v(din_tx_v), .din_tx(din_tx), .dout(d2_dout), .dout_v(d2_dv), .busy(d2_busy),
        .illegal_op(d2_ill), .alumode(d2_alu), .inmode(d2_inm), .opmode(d2_opm),
        .cea2(d2_cea), .ceb2(d2_ceb), .usemult(d2_um));
    pe_ctrl_seq #(.NUM_DSP(8), .LAT(10)) dut8 (
        .clk(clk), .rst(rst), .inst_if(if8),
        .din_pe_v(din_pe_v), .din_pe(din_pe), .din_shift_v(din_shift_v), .din_shift(din_shift),
        .din_tx_v(din_tx_v), .din_tx(din_tx), .dout(d8_dout), .dout_v(d8_dv), .busy(d8_busy),
        .illegal_op(d8_ill), .alumode(d8_alu), .inmode(d8_inm), .opmode(d8_opm),
        .cea2(d8_cea), .ceb2(d8_ceb), .usemult(d8_um));

    int checks = 0;
    int errors = 0;

    // Expected issue cycles and illegal pulses, written by the stimulus tasks.
    bit exp_issue [0:2047];
    bit exp_ill   [0:2047];
    int kill_cyc = -1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, got, want);
        end
    endtask

    function automatic bit live(int i, int c);
        return (i >= 0) && exp_issue[i] && !(i < kill_cyc && kill_cyc <= c);
    endfunction

    function automatic bit exp_dv(int c, int lat);
        return live(c - lat, c);
    endfunction

    function automatic bit exp_busy(int c, int lat);
        bit b = exp_issue[c];
        for (int i = c - lat; i < c; i++) if (live(i, c)) b = 1'b1;
        return b;
    endfunction

    always @(negedge clk) begin
        chk("dout_v_lat7", d4_dv, exp_dv(cyc, 7));
        chk("dout_v_lat2", d2_dv, exp_dv(cyc, 2));
        chk("dout_v_lat10", d8_dv, exp_dv(cyc, 10));
        chk("busy_lat7", d4_busy, exp_busy(cyc, 7));
        chk("busy_lat2", d2_busy, exp_busy(cyc, 2));
        chk("busy_lat10", d8_busy, exp_busy(cyc, 10));
        chk("illegal_op", d4_ill, exp_ill[cyc]);
        if (!exp_issue[cyc])
            chk("nop_ctrl", {d4_alu, d4_inm, d4_opm, d4_cea, d4_ceb, d4_um}, '0);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input int rep);
        int t = cyc;
        chk("inst_rdy_at_send", if4.inst_rdy, 1'b1);
        inst_v  = 1'b1;
        opcode  = op;
        rep_cnt = rep[CW-1:0];
        if (op == 3'b011) exp_ill[t+1] = 1'b1;
        else for (int j = 0; j <= rep; j++) exp_issue[t+1+j] = 1'b1;
        @(posedge clk);
        #1;
        inst_v = 1'b0;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] alu_e, alu_o;
        logic [4:0] inm;
        logic [6:0] opm_e, opm_o;
        logic       ce, um;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] ea;
    logic [39:0] ei;
    logic [55:0] eo;
    logic [7:0]  ec, eu;
    int          t0;

    initial begin
        vecs[0] = '{3'b000, 4'h0, 4'h0, 5'h00, 7'h00, 7'h00, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 4'h0, 4'h0, 5'h00, 7'h33, 7'h33, 1'b1, 1'b0};
        vecs[2] = '{3'b010, 4'h3, 4'h3, 5'h00, 7'h33, 7'h33, 1'b1, 1'b0};
        vecs[3] = '{3'b100, 4'h0, 4'h0, 5'h11, 7'h05, 7'h05, 1'b0, 1'b1};
        vecs[4] = '{3'b101, 4'h0, 4'h0, 5'h11, 7'h05, 7'h35, 1'b0, 1'b1};
        vecs[5] = '{3'b110, 4'h0, 4'h3, 5'h11, 7'h05, 7'h35, 1'b0, 1'b1};
        vecs[6] = '{3'b111, 4'h0, 4'h0, 5'h11, 7'h05, 7'h05, 1'b0, 1'b1};

        wait_cyc(3);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", {d4_dout, d4_dv, d4_busy, d4_ill, if4.inst_rdy}, {32'h0, 4'b0001});
            @(posedge clk);
            #1;
        end

        for (int v = 0; v < 7; v++) begin
            for (int l = 0; l < 8; l++) begin
                ea[l*4 +: 4] = (l % 2 == 1) ? vecs[v].alu_o : vecs[v].alu_e;
                ei[l*5 +: 5] = vecs[v].inm;
                eo[l*7 +: 7] = (l % 2 == 1) ? vecs[v].opm_o : vecs[v].opm_e;
                ec[l]        = vecs[v].ce;
                eu[l]        = vecs[v].um;
            end
            send(vecs[v].op, 0);
            chk("alu_4lane", d4_alu, ea[15:0]);
            chk("inm_4lane", d4_inm, ei[19:0]);
            chk("opm_4lane", d4_opm, eo[27:0]);
            chk("en_4lane", {d4_cea, d4_ceb, d4_um}, {ec[3:0], ec[3:0], eu[3:0]});
            chk("ctrl_2lane", {d2_alu, d2_inm, d2_opm, d2_cea, d2_ceb, d2_um},
                {ea[7:0], ei[9:0], eo[13:0], ec[1:0], ec[1:0], eu[1:0]});
            chk("ctrl_8lane", {d8_alu, d8_inm, d8_opm, d8_cea, d8_ceb, d8_um},
                {ea, ei, eo, ec, ec, eu});
            wait_cyc(12);
        end

        send(3'b001, 3);
        for (int j = 0; j < 4; j++) begin
            chk("add_opmode", d4_opm, {4{7'h33}});
            chk("add_cea2", d4_cea, 4'hf);
            wait_cyc(1);
        end
        wait_cyc(12);

        send(3'b101, 0);
        chk("muladd_opmode", d4_opm, {7'h35, 7'h05, 7'h35, 7'h05});
        chk("muladd_alumode", d4_alu, 16'h0000);
        send(3'b110, 1);
        chk("mulsub_opmode_c1", d4_opm, {7'h35, 7'h05, 7'h35, 7'h05});
        chk("mulsub_alumode_c1", d4_alu, 16'h3030);
        chk("rdy_low_while_cnt", if4.inst_rdy, 1'b0);
        wait_cyc(1);
        chk("mulsub_opmode_c2", d4_opm, {7'h35, 7'h05, 7'h35, 7'h05});
        chk("mulsub_alumode_c2", d4_alu, 16'h3030);
        wait_cyc(13);

        send(3'b011, 7);
        chk("illegal_pulse", d4_ill, 1'b1);
        chk("illegal_rdy", if4.inst_rdy, 1'b1);
        wait_cyc(1);
        chk("illegal_single", d4_ill, 1'b0);
        wait_cyc(12);

        din_pe_v = 1'b1;    din_pe    = 32'hAAAA5555;
        din_shift_v = 1'b1; din_shift = 32'hBEEF0001;
        din_tx_v = 1'b1;    din_tx    = 32'h0BAD0002;
        wait_cyc(1);
        chk("mux_pe_priority", d4_dout, 32'hAAAA5555);
        din_pe_v = 1'b0; din_shift_v = 1'b0; din_tx = 32'h12345678;
        wait_cyc(1);
        chk("mux_tx_only", d4_dout, 32'h12345678);
        din_tx_v = 1'b0; din_tx = 32'h55555555; din_pe = 32'h66666666;
        wait_cyc(2);
        chk("mux_hold", d4_dout, 32'h12345678);
        din_shift_v = 1'b1; din_shift = 32'hCAFEF00D; din_tx_v = 1'b1;
        wait_cyc(1);
        chk("mux_shift_over_tx", d4_dout, 32'hCAFEF00D);
        chk("mux_lat10_copy", d8_dout, 32'hCAFEF00D);
        din_shift_v = 1'b0; din_tx_v = 1'b0;
        wait_cyc(1);

        t0 = cyc;
        send(3'b100, 10);
        for (int c = t0 + 7; c <= t0 + 11; c++) exp_issue[c] = 1'b0;
        kill_cyc = t0 + 7;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(1);
        chk("rst_mid_data", {d4_dout, d4_dv, d4_busy, d4_ill}, '0);
        chk("rst_mid_ctrl", {d4_alu, d4_inm, d4_opm, d4_cea, d4_ceb, d4_um}, '0);
        chk("rst_mid_ctrl8", {d8_alu, d8_inm, d8_opm, d8_cea, d8_ceb, d8_um}, '0);
        chk("rst_mid_misc", {d2_dout, d2_dv, d2_busy, d8_dout, d8_dv, d8_busy}, '0);
        rst = 1'b0;
        wait_cyc(14);
        chk("rdy_after_rst", if4.inst_rdy, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
